// File: rtl/shifter_if.sv
// ---------------------------------------------------------------------------
// shifter_if -- operand/amount/direction bundle and registered result for
// the shifter.
//   input_port_1   : signed operand to be shifted          (master -> slave)
//   input_port_2   : shift amount, low SHAMT_W bits count   (master -> slave)
//   control_signal : 0 = arithmetic right, 1 = logical left (master -> slave)
//   output_latch   : registered shift result                (slave -> master)
// ---------------------------------------------------------------------------
interface shifter_if #(
   parameter int DATA_W = 64
);
   logic signed [DATA_W-1:0] input_port_1;
   logic        [DATA_W-1:0] input_port_2;
   logic                     control_signal;
   logic signed [DATA_W-1:0] output_latch;

   modport master (
      output input_port_1, input_port_2, control_signal,
      input  output_latch
   );

   modport slave (
      input  input_port_1, input_port_2, control_signal,
      output output_latch
   );
endinterface

// File: rtl/shifter.sv
// ---------------------------------------------------------------------------
// shifter -- logarithmic barrel shifter with a single output register.
//   clk   : clock, all state on the rising edge
//   rst_n : synchronous active-low reset, clears output_latch
//   bus   : shifter_if.slave (operand, amount, direction in; result out)
// Stage k shifts by 2^k when amount bit k is set. Right shifts are
// arithmetic (sign fill), left shifts are logical (zero fill).
// Optional macro SHIFTER_RANGE_CHECK_EN: any set amount bit above SHAMT_W-1
// saturates the result (left -> 0, right -> all sign bits). Without it those
// bits are ignored, i.e. the amount is taken modulo DATA_W.
// ---------------------------------------------------------------------------
module shifter #(
   parameter int DATA_W  = 64,
   parameter int SHAMT_W = 6
) (
   input  logic     clk,
   input  logic     rst_n,
   shifter_if.slave bus
);

   logic [SHAMT_W-1:0]             amt;
   logic                           sgn;
   logic                           dir_left;
   logic [SHAMT_W:0][DATA_W-1:0]   stg;
   logic [DATA_W-1:0]              res;
   logic [DATA_W-1:0]              out_d, out_q;

   assign amt      = bus.input_port_2[SHAMT_W-1:0];
   assign sgn      = bus.input_port_1[DATA_W-1];
   assign dir_left = bus.control_signal;
   assign stg[0]   = bus.input_port_1;

   // Right-shift fill uses the original operand's sign bit, which every
   // stage still carries in its MSB, so one sign tap serves all stages.
   for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
      localparam int SH = 1 << k;
      logic [DATA_W-1:0] shl, shr;
      assign shl = {stg[k][DATA_W-1-SH:0], {SH{1'b0}}};
      assign shr = {{SH{sgn}}, stg[k][DATA_W-1:SH]};
      assign stg[k+1] = !amt[k] ? stg[k] : (dir_left ? shl : shr);
   end

`ifdef SHIFTER_RANGE_CHECK_EN
   logic oor;
   assign oor = |bus.input_port_2[DATA_W-1:SHAMT_W];

   always_comb begin
      res = stg[SHAMT_W];
      if (oor) res = dir_left ? '0 : {DATA_W{sgn}};
   end
`else
   // Upper amount bits are deliberately dropped (modulo DATA_W).
   logic unused_amt_hi;
   assign unused_amt_hi = ^bus.input_port_2[DATA_W-1:SHAMT_W];
   assign res = stg[SHAMT_W];
`endif

   assign out_d = res;

   always_ff @(posedge clk) begin
      if (!rst_n) out_q <= '0;
      else        out_q <= out_d;
   end

   assign bus.output_latch = out_q;

endmodule

// File: tb/tb_shifter.sv
// ---------------------------------------------------------------------------
// tb_shifter -- directed vectors with hand-computed results for shifter.
// Inputs change just after a rising edge; results are sampled 1 ns after
// the edge that loads them.
// ---------------------------------------------------------------------------
module tb_shifter;
   localparam int DATA_W  = 64;
   localparam int SHAMT_W = 6;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;

   shifter_if #(.DATA_W(DATA_W)) bus ();

   shifter #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", tag, act, exp);
      end
   endtask

   task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic c);
      bus.input_port_1   = a;
      bus.input_port_2   = b;
      bus.control_signal = c;
   endtask

   task automatic step(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic c, input logic [63:0] exp);
      drive(a, b, c);
      @(posedge clk); #1;
      chk(tag, bus.output_latch, exp);
   endtask

   localparam logic [63:0] PAT = 64'hDB6DB6DB6DB6DB6D;

   initial begin
      // reset for two edges with arbitrary inputs
      rst_n = 1'b0;
      drive(PAT, 64'h5, 1'b1);
      @(posedge clk); #1; chk("rst_edge1", bus.output_latch, 64'h0);
      drive(64'h1234, 64'h3, 1'b0);
      @(posedge clk); #1; chk("rst_edge2", bus.output_latch, 64'h0);

      // first edge after release loads the present inputs
      rst_n = 1'b1;
      step("first_after_rst", 64'hF0, 64'h4, 1'b0, 64'h0F);

      step("sar_22",  PAT, 64'h16, 1'b0, 64'hFFFFFF6DB6DB6DB6);
      step("shl_22",  PAT, 64'h16, 1'b1, 64'hB6DB6DB6DB400000);
      step("sar_63",  64'h8000000000000000, 64'd63, 1'b0, 64'hFFFFFFFFFFFFFFFF);
      step("shl_63",  64'h1, 64'd63, 1'b1, 64'h8000000000000000);
      step("sar_0",   64'h0123456789ABCDEF, 64'h0, 1'b0, 64'h0123456789ABCDEF);
      step("shl_0",   64'h0123456789ABCDEF, 64'h0, 1'b1, 64'h0123456789ABCDEF);
      step("sar_pos", 64'h7000000000000000, 64'd60, 1'b0, 64'h7);
      step("shl_1",   64'h1, 64'h1, 1'b1, 64'h2);

      // inputs changed between edges must not disturb the register
      drive(64'hFFFF, 64'h8, 1'b1);
      #3; chk("hold_between_edges", bus.output_latch, 64'h2);
      @(posedge clk); #1; chk("load_after_change", bus.output_latch, 64'hFF_FF00);

      // out-of-range amounts
`ifdef SHIFTER_RANGE_CHECK_EN
      step("oor_shl_40", PAT, 64'h40, 1'b1, 64'h0);
      step("oor_sar_40", PAT, 64'h40, 1'b0, 64'hFFFFFFFFFFFFFFFF);
      step("oor_sar_41", 64'h8000000000000000, 64'h41, 1'b0, 64'hFFFFFFFFFFFFFFFF);
      step("oor_shl_41", 64'h3, 64'h41, 1'b1, 64'h0);
`else
      step("oor_shl_40", PAT, 64'h40, 1'b1, PAT);
      step("oor_sar_40", PAT, 64'h40, 1'b0, PAT);
      step("oor_sar_41", 64'h8000000000000000, 64'h41, 1'b0, 64'hC000000000000000);
      step("oor_shl_41", 64'h3, 64'h41, 1'b1, 64'h6);
`endif

      // mid-stream reset discards the pending result, release reloads
      drive(PAT, 64'h4, 1'b1);
      rst_n = 1'b0;
      @(posedge clk); #1; chk("midstream_rst", bus.output_latch, 64'h0);
      rst_n = 1'b1;
      step("after_mid_rst", PAT, 64'h4, 1'b1, 64'hB6DB6DB6DB6DB6D0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
